// File: rtl/ro_puf_pkg.sv
// Shared RO PUF definitions: measurement FSM states and default widths/window
// used by the pair counter and the downstream count comparator.
package ro_puf_pkg;

    localparam int DEF_SIZE        = 32;
    localparam int DEF_WINDOW      = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// One ring-oscillator channel: synchronizer, rising-edge detector and a
// saturating edge counter with a sticky saturation flag.
module ro_edge_counter #(
    parameter int SIZE        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ro,
    input  logic            clear,
    input  logic            enable,
    output logic [SIZE-1:0] count_nxt,
    output logic            sat_nxt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_dly_q, sync_dly_d;
    logic [SIZE-1:0]        count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   rise;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ro};
        sync_dly_d = sync_q[SYNC_STAGES-1];
        rise       = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
        count_d    = count_q;
        sat_d      = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (enable && rise && (count_q != {SIZE{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
            // Sticky: once the counter pins at all-ones it stays flagged until the next clear.
            sat_d = sat_q | (count_d == {SIZE{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            count_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
        end
    end

    assign count_nxt = count_d;
    assign sat_nxt   = sat_d;

endmodule

// File: rtl/ro_pair_counter.sv
// RO PUF measurement stage: counts RO1/RO2 rising edges over a fixed window.
// state | meaning: IDLE wait Start | ARM flush synchronizers | COUNT window | DONE strobe
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic            RO1,
    input  logic            RO2,
    output logic            Busy,
    output logic            Done,
    output logic [SIZE-1:0] Count1,
    output logic [SIZE-1:0] Count2,
    output logic            Overflow
);

    localparam int TW = $clog2(WINDOW + 1);
    localparam int AW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW - 1);
    localparam logic [AW-1:0] ARM_LOAD = AW'(SYNC_STAGES);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   arm_q, arm_d;
    logic [SIZE-1:0] count1_q, count1_d, count2_q, count2_d;
    logic            ovf_q, ovf_d;
    logic            clear, enable;
    logic [SIZE-1:0] cnt1_nxt, cnt2_nxt;
    logic            sat1_nxt, sat2_nxt;

    ro_edge_counter #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) u_ch1 (
        .clk(Clk), .rst_n(Rst_n), .ro(RO1), .clear(clear), .enable(enable),
        .count_nxt(cnt1_nxt), .sat_nxt(sat1_nxt)
    );

    ro_edge_counter #(.SIZE(SIZE), .SYNC_STAGES(SYNC_STAGES)) u_ch2 (
        .clk(Clk), .rst_n(Rst_n), .ro(RO2), .clear(clear), .enable(enable),
        .count_nxt(cnt2_nxt), .sat_nxt(sat2_nxt)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        arm_d    = arm_q;
        count1_d = count1_q;
        count2_d = count2_q;
        ovf_d    = ovf_q;
        clear    = 1'b0;
        enable   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    clear   = 1'b1;
                    arm_d   = ARM_LOAD;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (arm_q == '0) begin
                    timer_d = WIN_LOAD;
                    state_d = COUNT;
                end else begin
                    arm_d = arm_q - AW'(1);
                end
            end
            COUNT: begin
                enable = 1'b1;
                if (timer_q == '0) begin
                    // Capture next-state counts so an edge in the final window cycle is included.
                    count1_d = cnt1_nxt;
                    count2_d = cnt2_nxt;
                    ovf_d    = sat1_nxt | sat2_nxt;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            arm_q    <= '0;
            count1_q <= '0;
            count2_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            arm_q    <= arm_d;
            count1_q <= count1_d;
            count2_q <= count2_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign Count1   = count1_q;
    assign Count2   = count2_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Bench for ro_pair_counter: scoreboard of expected counts checked on each Done,
// plus latency, Start-filtering, async reset, back-to-back and saturation scenarios.
`timescale 1ns/1ps
module tb_ro_pair_counter;

    localparam int WIN = 120;

    typedef struct {
        int   c1_lo;
        int   c1_hi;
        int   c2_lo;
        int   c2_hi;
        logic ovf;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n, Start, RO1, RO2;
    logic        Busy, Done, Overflow;
    logic [31:0] Count1, Count2;

    logic        s_rst_n, s_start, s_ro1, s_ro2;
    logic        s_busy, s_done, s_ovf;
    logic [3:0]  s_count1, s_count2;

    int      errors = 0;
    int      checks = 0;
    int      done_cnt = 0;
    logic    done_prev = 1'b0;
    exp_t    sb[$];
    exp_t    e;

    realtime ro1_half = 50.0;
    realtime ro2_half = 60.0;
    bit      ro1_en = 1'b0;
    bit      ro2_en = 1'b0;
    bit      s_ro1_en = 1'b0;

    always #5 Clk = ~Clk;

    ro_pair_counter #(.SIZE(32), .WINDOW(WIN), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .RO1(RO1), .RO2(RO2),
        .Busy(Busy), .Done(Done), .Count1(Count1), .Count2(Count2), .Overflow(Overflow)
    );

    ro_pair_counter #(.SIZE(4), .WINDOW(64), .SYNC_STAGES(2)) dut_s (
        .Clk(Clk), .Rst_n(s_rst_n), .Start(s_start), .RO1(s_ro1), .RO2(s_ro2),
        .Busy(s_busy), .Done(s_done), .Count1(s_count1), .Count2(s_count2), .Overflow(s_ovf)
    );

    initial begin
        RO1 = 1'b0;
        #0.7;
        forever begin
            #(ro1_half);
            RO1 = ro1_en ? ~RO1 : 1'b0;
        end
    end

    initial begin
        RO2 = 1'b0;
        #2.3;
        forever begin
            #(ro2_half);
            RO2 = ro2_en ? ~RO2 : 1'b0;
        end
    end

    initial begin
        s_ro1 = 1'b0;
        #0.3;
        forever begin
            #10.0;
            s_ro1 = s_ro1_en ? ~s_ro1 : 1'b0;
        end
    end

    // Expected count for one window of WIN cycles at 10 ns, tolerance +-1 for phase.
    function automatic exp_t mk_exp(input bit en1, input realtime p1, input bit en2, input realtime p2);
        exp_t r;
        int   n1, n2;
        n1 = en1 ? int'((WIN * 10.0) / p1) : 0;
        n2 = en2 ? int'((WIN * 10.0) / p2) : 0;
        r.c1_lo = en1 ? n1 - 1 : 0;
        r.c1_hi = en1 ? n1 + 1 : 0;
        r.c2_lo = en2 ? n2 - 1 : 0;
        r.c2_hi = en2 ? n2 + 1 : 0;
        r.ovf   = 1'b0;
        return r;
    endfunction

    // Scoreboard: every Done pops one expectation and checks the result fields.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && Done === 1'b1) begin
            done_cnt++;
            checks++;
            if (done_prev === 1'b1) begin
                errors++;
                $display("FAIL done_width: Done high on consecutive cycles");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: Done with no accepted Start pending");
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (int'(Count1) < e.c1_lo || int'(Count1) > e.c1_hi) begin
                    errors++;
                    $display("FAIL sb_count1: got %0d want %0d..%0d", Count1, e.c1_lo, e.c1_hi);
                end
                if (int'(Count2) < e.c2_lo || int'(Count2) > e.c2_hi) begin
                    errors++;
                    $display("FAIL sb_count2: got %0d want %0d..%0d", Count2, e.c2_lo, e.c2_hi);
                end
                if (Overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL sb_overflow: got %b want %b", Overflow, e.ovf);
                end
            end
        end
        done_prev = Done;
    end

    // Pulse Start for one edge, then report Busy length and the cycle Done appeared.
    task automatic run_one(output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = 0;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (Busy) busy_n++;
            if (Done && done_at == 0) done_at = c;
            if (!Busy) break;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Rst_n   = 1'b0;
        s_rst_n = 1'b0;
        Start   = 1'b0;
        s_start = 1'b0;
        s_ro2   = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({Busy, Done, Count1, Count2, Overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b c1=%0d c2=%0d ovf=%b want all 0",
                     Busy, Done, Count1, Count2, Overflow);
        end
        checks++;
        if ({s_busy, s_done, s_count1, s_count2, s_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_sat: got busy=%b done=%b c1=%0d c2=%0d ovf=%b want all 0",
                     s_busy, s_done, s_count1, s_count2, s_ovf);
        end
        @(negedge Clk);
        Rst_n   = 1'b1;
        s_rst_n = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_idle_window();
        int busy_n, done_at;
        sb.push_back(mk_exp(1'b0, 100.0, 1'b0, 120.0));
        run_one(busy_n, done_at);
        checks++;
        if (busy_n != 124) begin
            errors++;
            $display("FAIL idle_busy_len: got %0d cycles want 124", busy_n);
        end
        checks++;
        if (done_at != 124) begin
            errors++;
            $display("FAIL idle_done_cycle: got %0d want 124", done_at);
        end
    endtask

    task automatic test_two_ros();
        int busy_n, done_at;
        ro1_half = 50.0;
        ro2_half = 60.0;
        ro1_en   = 1'b1;
        ro2_en   = 1'b1;
        repeat (20) @(posedge Clk);
        sb.push_back(mk_exp(1'b1, 100.0, 1'b1, 120.0));
        run_one(busy_n, done_at);
        checks++;
        if (done_at != 124) begin
            errors++;
            $display("FAIL ros_done_cycle: got %0d want 124", done_at);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        sb.push_back(mk_exp(1'b1, 100.0, 1'b1, 120.0));
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (50) @(posedge Clk);
        #1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                seen  = 1'b1;
                Start = 1'b1;
                @(posedge Clk);
                #1;
                Start = 1'b0;
                break;
            end
        end
        repeat (150) @(posedge Clk);
        #1;
        checks++;
        if (!seen || (done_cnt - d0) != 1) begin
            errors++;
            $display("FAIL ignored_start_dones: got %0d Done pulses want 1", done_cnt - d0);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_busy: got %b want 0", Busy);
        end
    endtask

    task automatic test_async_reset();
        int busy_n, done_at;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (60) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Count1, Count2, Overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got busy=%b c1=%0d c2=%0d ovf=%b want all 0",
                     Busy, Count1, Count2, Overflow);
        end
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        sb.push_back(mk_exp(1'b1, 100.0, 1'b1, 120.0));
        run_one(busy_n, done_at);
        checks++;
        if (busy_n != 124) begin
            errors++;
            $display("FAIL post_reset_busy_len: got %0d want 124", busy_n);
        end
        checks++;
        if (done_at != 124) begin
            errors++;
            $display("FAIL post_reset_done_cycle: got %0d want 124", done_at);
        end
    endtask

    task automatic test_back_to_back();
        int  second_at;
        bit  restarted;
        second_at = 0;
        restarted = 1'b0;
        ro2_half  = 60.0;
        sb.push_back(mk_exp(1'b1, 100.0, 1'b1, 120.0));
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge Clk);
            #1;
            if (Done) break;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got Done=%b want 1 within 300 cycles", Done);
        end
        ro2_half = 40.0;
        sb.push_back(mk_exp(1'b1, 100.0, 1'b1, 80.0));
        for (int c = 1; c <= 300; c++) begin
            @(posedge Clk);
            #1;
            if (!restarted && Busy) begin
                restarted = 1'b1;
                Start     = 1'b0;
            end
            if (c == 60) begin
                checks++;
                if (int'(Count2) < 9 || int'(Count2) > 11) begin
                    errors++;
                    $display("FAIL b2b_hold_count2: got %0d want 9..11", Count2);
                end
            end
            if (Done) begin
                second_at = c;
                break;
            end
        end
        Start = 1'b0;
        checks++;
        if (second_at != 125) begin
            errors++;
            $display("FAIL b2b_second_done: got cycle %0d want 125", second_at);
        end
        repeat (5) @(posedge Clk);
    endtask

    task automatic test_saturation();
        int done_at;
        done_at  = 0;
        s_ro1_en = 1'b1;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        s_start = 1'b1;
        @(posedge Clk);
        #1;
        s_start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (s_done) begin
                done_at = c;
                break;
            end
            @(posedge Clk);
            #1;
        end
        checks++;
        if (done_at != 68) begin
            errors++;
            $display("FAIL sat_done_cycle: got %0d want 68", done_at);
        end
        checks++;
        if (s_count1 !== 4'd15 || s_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_count1_ovf: got c1=%0d ovf=%b want c1=15 ovf=1", s_count1, s_ovf);
        end
        checks++;
        if (s_count2 !== 4'd0) begin
            errors++;
            $display("FAIL sat_count2: got %0d want 0", s_count2);
        end
        s_ro1_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_window();
        test_two_ros();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_saturation();
        repeat (5) @(posedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: got %0d unconsumed expectations want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
